// File: rtl/main_memory_pkg.sv
// rtl/main_memory_pkg.sv - shared FSM encoding and width helper for the line interface
package main_memory_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESPOND = 3'd4
  } state_e;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/main_memory_line_interface.sv
// rtl/main_memory_line_interface.sv - serializes cache-line requests into single-word BRAM accesses
module main_memory_line_interface
  import main_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDR_WIDTH-1:0]              req_address,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] req_data,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic                               resp_write,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] resp_data,
  output logic                               bram_readEnable,
  output logic                               bram_writeEnable,
  output logic [ADDR_WIDTH-1:0]              bram_address,
  output logic [DATA_WIDTH-1:0]              bram_writeData,
  input  logic [DATA_WIDTH-1:0]              bram_readData
);

  localparam int OFFSET_BITS = log2_ceil(WORDS_PER_LINE);
  localparam logic [OFFSET_BITS-1:0] LAST_CNT    = OFFSET_BITS'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0]  OFFSET_MASK = ADDR_WIDTH'(WORDS_PER_LINE - 1);

  typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_t;

  state_e                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic                   write_q, write_d;
  line_t                  wline_q, wline_d;
  line_t                  rline_q, rline_d;

  logic                   accept;
  logic                   cnt_last;
  logic [OFFSET_BITS-1:0] slot_prev;
  logic [ADDR_WIDTH-1:0]  word_addr;

  assign req_ready = (state_q == ST_IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign cnt_last  = (cnt_q == LAST_CNT);
  assign slot_prev = cnt_q - OFFSET_BITS'(1);
  // Base has its offset field cleared, so OR-ing the counter never carries out of the line.
  assign word_addr = base_q | ADDR_WIDTH'(cnt_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = req_write ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        if (cnt_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_RESPOND;
      end
      ST_WRITE: begin
        if (cnt_last) state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    resp_valid       = 1'b0;
    bram_readEnable  = 1'b0;
    bram_writeEnable = 1'b0;
    bram_address     = '0;
    bram_writeData   = '0;
    case (state_q)
      ST_READ: begin
        bram_readEnable = 1'b1;
        bram_address    = word_addr;
      end
      ST_WRITE: begin
        bram_writeEnable = 1'b1;
        bram_address     = word_addr;
        bram_writeData   = wline_q[cnt_q];
      end
      ST_RESPOND: begin
        resp_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Read data lags the issued address by one cycle, so slot k-1 fills while word k is issued.
  always_comb begin
    cnt_d   = cnt_q;
    base_d  = base_q;
    write_d = write_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          base_d  = req_address & ~OFFSET_MASK;
          write_d = req_write;
          wline_d = line_t'(req_data);
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (cnt_q != '0) rline_d[slot_prev] = bram_readData;
        if (!cnt_last) cnt_d = cnt_q + OFFSET_BITS'(1);
      end
      ST_DRAIN: begin
        rline_d[LAST_CNT] = bram_readData;
      end
      ST_WRITE: begin
        if (!cnt_last) cnt_d = cnt_q + OFFSET_BITS'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      base_q  <= '0;
      write_q <= 1'b0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      write_q <= write_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  assign resp_write = write_q;
  assign resp_data  = rline_q;

endmodule

// File: tb/tb_main_memory_line_interface.sv
// tb/tb_main_memory_line_interface.sv - randomized self-checking bench with BRAM and line-level reference model
module tb_main_memory_line_interface;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N  = 4;
  localparam int LW = DW * N;
  localparam int EW = 2 + AW + DW;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [LW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_write;
  logic [LW-1:0] resp_data;
  logic          bram_readEnable;
  logic          bram_writeEnable;
  logic [AW-1:0] bram_address;
  logic [DW-1:0] bram_writeData;
  logic [DW-1:0] bram_readData;

  main_memory_line_interface #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(N)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_data(resp_data),
    .bram_readEnable(bram_readEnable), .bram_writeEnable(bram_writeEnable),
    .bram_address(bram_address), .bram_writeData(bram_writeData),
    .bram_readData(bram_readData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] mem_init(input int a);
    if (a >= 16 && a <= 19) return 32'hA0 + 32'(a - 16);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // BRAM port 1 model: synchronous read, write on the edge.
  logic [DW-1:0] mem [0:255];
  logic          preload_en;
  always @(posedge clock) begin
    if (preload_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else begin
      if (bram_writeEnable) mem[bram_address] <= bram_writeData;
      if (bram_readEnable) bram_readData <= mem[bram_address];
    end
  end

  logic [EW-1:0] acc_q [$];
  always @(posedge clock) begin
    if (bram_readEnable || bram_writeEnable)
      acc_q.push_back({bram_writeEnable, bram_readEnable, bram_address, bram_writeData});
  end

  // Reference model: memory contents and last returned read line.
  logic [DW-1:0] ref_mem [0:255];
  logic [LW-1:0] last_line;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] line, input int hold);
    logic [AW-1:0] base;
    logic [AW-1:0] ak;
    logic [LW-1:0] exp_resp;
    logic [LW-1:0] snap;
    logic [EW-1:0] ent;
    logic [DW-1:0] wexp;
    int            guard;
    int            lat;
    base = addr & 8'hFC;
    acc_q.delete();
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_data    = line;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check_eq("accept_ready_now", guard, 0);
    @(negedge clock);
    req_valid   = 1'b0;
    req_address = AW'($urandom);
    req_data    = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!resp_valid && lat < 40) begin
      if (req_ready) check_eq("busy_req_ready", req_ready, 1'b0);
      @(negedge clock);
      lat++;
    end
    check_eq(wr ? "wr_latency" : "rd_latency", lat, wr ? N : N + 1);
    if (wr) begin
      for (int k = 0; k < N; k++) begin
        ak = base + AW'(k);
        ref_mem[ak] = line[k*DW +: DW];
      end
      exp_resp = last_line;
    end else begin
      for (int k = 0; k < N; k++) begin
        ak = base + AW'(k);
        exp_resp[k*DW +: DW] = ref_mem[ak];
      end
      last_line = exp_resp;
    end
    check_eq("resp_write", resp_write, wr);
    check_eq("resp_data", resp_data, exp_resp);
    snap = resp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_eq("hold_valid", resp_valid, 1'b1);
      check_eq("hold_data", resp_data, snap);
      check_eq("hold_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check_eq("post_resp_valid", resp_valid, 1'b0);
    check_eq("post_req_ready", req_ready, 1'b1);
    check_eq("access_count", acc_q.size(), N);
    for (int k = 0; k < N && k < acc_q.size(); k++) begin
      ak   = base + AW'(k);
      wexp = wr ? line[k*DW +: DW] : '0;
      ent  = {wr, !wr, ak, wexp};
      check_eq("bram_access", acc_q[k], ent);
    end
  endtask

  logic [LW-1:0] wline;
  logic [DW-1:0] old42, old43;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    last_line   = '0;
    preload_en  = 1'b1;
    reset       = 1'b0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = '0;
    req_data    = '0;
    resp_ready  = 1'b0;
    repeat (3) @(negedge clock);
    preload_en = 1'b0;
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_resp_write", resp_write, 1'b0);
    check_eq("rst_resp_data", resp_data, '0);
    check_eq("rst_bram", {bram_readEnable, bram_writeEnable, bram_address, bram_writeData}, '0);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("ready_after_release", req_ready, 1'b1);
    @(negedge clock);

    // Directed read of preloaded line, offset bits ignored.
    run_txn(1'b0, 8'h12, '0, 0);
    check_eq("preload_line", resp_data, 128'h000000A3_000000A2_000000A1_000000A0);

    wline = 128'h11112222_33334444_55556666_77778888;
    run_txn(1'b1, 8'h20, wline, 0);
    run_txn(1'b0, 8'h20, '0, 10);
    check_eq("readback_0x20", last_line, wline);

    // Top and bottom of memory, back to back.
    run_txn(1'b0, 8'hFD, '0, 0);
    run_txn(1'b1, 8'hFE, {$urandom, $urandom, $urandom, $urandom}, 0);
    run_txn(1'b0, 8'h03, '0, 0);
    run_txn(1'b0, 8'hFC, '0, 1);

    // Reset asserted in the third write cycle at 0x40.
    old42 = ref_mem[8'h42];
    old43 = ref_mem[8'h43];
    wline = {$urandom, $urandom, $urandom, $urandom};
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_address = 8'h41;
    req_data    = wline;
    check_eq("rst_test_ready", req_ready, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_bram", {bram_readEnable, bram_writeEnable, bram_address, bram_writeData}, '0);
    check_eq("mid_rst_resp", {resp_valid, resp_write}, '0);
    check_eq("mid_rst_data", resp_data, '0);
    check_eq("mid_rst_ready", req_ready, 1'b0);
    repeat (3) begin
      @(negedge clock);
      check_eq("mid_rst_no_resp", resp_valid, 1'b0);
    end
    reset = 1'b1;
    #1;
    check_eq("mid_rst_release_ready", req_ready, 1'b1);
    check_eq("mem_40", mem[8'h40], wline[0*DW +: DW]);
    check_eq("mem_41", mem[8'h41], wline[1*DW +: DW]);
    check_eq("mem_42", mem[8'h42], old42);
    check_eq("mem_43", mem[8'h43], old43);
    ref_mem[8'h40] = wline[0*DW +: DW];
    ref_mem[8'h41] = wline[1*DW +: DW];
    last_line = '0;
    @(negedge clock);
    run_txn(1'b0, 8'h40, '0, 0);

    // Random traffic against the reference model.
    for (int t = 0; t < 30; t++) begin
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/main_memory_line_interface.md
# main_memory_line_interface

Line-to-word sequencer between the cache hierarchy and the main-memory dual-port BRAM. It accepts one cache-line read or write request at a time over a valid/ready handshake. It serializes the request into `WORDS_PER_LINE` single-word accesses on one BRAM port, assembles read words into a line buffer, and returns a line response (read data or write acknowledge) over a second valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32: BRAM word width.
- `ADDR_WIDTH`, 8: BRAM word-address width.
- `WORDS_PER_LINE`, 4: words per cache line; power of 2, ≥2, ≤2^ADDR_WIDTH.
- `OFFSET_BITS`, derived localparam = log2(WORDS_PER_LINE): word-offset field width.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE and reset deasserted.
- `req_write`  in  1  1 = line write, 0 = line read.
- `req_address`  in  ADDR_WIDTH  word address of line; low OFFSET_BITS ignored (forced to 0).
- `req_data`  in  DATA_WIDTH*WORDS_PER_LINE  write line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_write`  out  1  echo of accepted req_write.
- `resp_data`  out  DATA_WIDTH*WORDS_PER_LINE  read line, same word packing.
- `bram_readEnable`  out  1  to BRAM port readEnable.
- `bram_writeEnable`  out  1  to BRAM port writeEnable.
- `bram_address`  out  ADDR_WIDTH  to BRAM port address.
- `bram_writeData`  out  DATA_WIDTH  to BRAM port writeData.
- `bram_readData`  in  DATA_WIDTH  from BRAM port readData; valid the cycle after a cycle with readEnable=1.

## Operation
- States: IDLE, READ, DRAIN, WRITE, RESPOND.
- IDLE: `req_ready`=1. On `req_valid & req_ready`: latch base = req_address with offset cleared, latch req_write and req_data, clear word counter `cnt`, go to READ or WRITE.
- READ, `cnt`=k: `bram_readEnable`=1, `bram_address`=base+k. Capture `bram_readData` into slot k-1 when k≥1. At k=N-1, go to DRAIN; otherwise `cnt`++.
- DRAIN: no BRAM enables. Capture `bram_readData` into slot N-1. Go to RESPOND.
- WRITE, `cnt`=k: `bram_writeEnable`=1, `bram_address`=base+k, `bram_writeData`=latched word k. At k=N-1, go to RESPOND.
- RESPOND: `resp_valid`=1. Hold `resp_data` and `resp_write` stable. On `resp_ready`, go to IDLE.
- BRAM enables are 0 in IDLE, DRAIN and RESPOND. `bram_writeData`=0 when not writing.
- Address arithmetic: base+k uses only the offset field (OR into low OFFSET_BITS). No carry and no wrap out of the line.
- Requests arriving outside IDLE are not accepted. The requester holds them, per valid/ready rules.
- `resp_data` changes only on read captures. A write response leaves the previous line contents in place.

## Timing
- Reset (reset=0, async) gives:
  - state=IDLE, `cnt`=0.
  - `req_ready`=0 while reset is asserted.
  - `resp_valid`=0, `resp_write`=0, `resp_data`=0.
  - All `bram_*` outputs = 0.
- `req_ready` rises combinationally once reset=1.
- Read latency: accept at edge E0; `resp_valid` high from edge E(N+1) (N issue cycles + 1 drain). For N=4, resp_valid rises 5 edges after accept.
- Write latency: accept at E0; `resp_valid` high from E(N). For N=4, 4 edges.
- Back-to-back: response handshake at edge Ex makes the state IDLE after Ex. A new request can be accepted at Ex+1, so there is a minimum one-cycle gap.
- `resp_ready` held low: stay in RESPOND indefinitely, outputs stable.
- Reset mid-operation: abort immediately, return to IDLE, no response. BRAM words already written stay written; there is no rollback.

## Structure
- Shared package/header (`main_memory_pkg`): state encodings (IDLE=0, READ=1, DRAIN=2, WRITE=3, RESPOND=4; 3-bit) and the log2 helper used for OFFSET_BITS.
- No sub-module. FSM, counter and line buffer stay in one module. The bench instantiates it with the dual-port BRAM on port 1.

## Test plan
- Preload BRAM[0x10..0x13]=0xA0,0xA1,0xA2,0xA3; read req_address=0x12 -> BRAM addresses 0x10..0x13 issued on 4 consecutive cycles; resp_valid 5 edges after accept; resp_data=0x000000A3_000000A2_000000A1_000000A0.
- Write line 0x1111_2222_3333_4444_..., address 0x20 -> writeEnable 4 cycles at 0x20..0x23; resp_valid after 4 edges with resp_write=1; a following read of 0x20 returns the same line.
- Hold resp_ready=0 for 10 cycles after a read -> resp_valid and resp_data stable; req_ready=0 throughout; second request accepted the cycle after resp_ready=1.
- Back-to-back read, write, read to lines 0xFC and 0x00 (top/bottom of memory) -> correct addresses, no wrap beyond line, each response matches.
- Assert reset=0 in the 3rd cycle of a write at 0x40 -> outputs immediately at reset values; no resp_valid; BRAM[0x40..0x41] updated, [0x42..0x43] unchanged; next request after release completes normally.
